// File: rtl/alu_pkg.sv
// Shared opcode/state types and helpers for the handshaked sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ITER = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [3:0] OP_LAST = 4'd9;

  function automatic logic is_iter(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_n.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide, one step per cycle.
module alu_iter_n
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  op_t          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] prod_lo,
  output logic [N-1:0] prod_hi,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem
);

  localparam int CW = $clog2(N);

  logic          r_active;
  logic          r_isMul;
  logic [CW-1:0] r_cnt;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]  r_mplier;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_div;

  logic [2*N-1:0] w_accNext;
  logic [N:0]     w_remSh;
  logic [N:0]     w_diff;
  logic           w_fit;
  logic [N-1:0]   w_remNext;
  logic [N-1:0]   w_quoNext;

  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Restoring step: shift the next dividend bit into the partial remainder and
  // keep the subtraction only when the divisor fits.
  assign w_remSh   = {r_rem, r_quo[N-1]};
  assign w_diff    = w_remSh - {1'b0, r_div};
  assign w_fit     = ~w_diff[N];
  assign w_remNext = w_fit ? w_diff[N-1:0] : w_remSh[N-1:0];
  assign w_quoNext = {r_quo[N-2:0], w_fit};

  // Outputs expose the result of the step taking place this cycle, so the
  // final values are ready while done is high.
  assign done    = r_active && (r_cnt == '0);
  assign prod_lo = w_accNext[N-1:0];
  assign prod_hi = w_accNext[2*N-1:N];
  assign quot    = w_quoNext;
  assign rem     = w_remNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_isMul  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_isMul  <= (op == OP_MUL);
      r_cnt    <= CW'(N-1);
      r_acc    <= '0;
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_rem    <= '0;
      r_quo    <= a;
      r_div    <= b;
    end else if (r_active) begin
      r_cnt <= r_cnt - 1'b1;
      if (done) begin
        r_active <= 1'b0;
      end
      if (r_isMul) begin
        r_acc    <= w_accNext;
        r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[N-1:1]};
      end else begin
        r_rem <= w_remNext;
        r_quo <= w_quoNext;
      end
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Handshaked ALU: captures an operation, executes it (iteratively for MUL/DIV/MOD)
// and holds result/flags until the consumer accepts them.
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [3:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         out_neg,
  output logic         out_cero,
  output logic         out_carry,
  output logic         out_des,
  output logic         busy
);

  state_t       r_state;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [3:0]   r_mode;
  logic [N-1:0] r_result;
  logic         r_neg;
  logic         r_cero;
  logic         r_carry;
  logic         r_des;
  logic         r_outValid;
  logic         r_inReady;
  logic         r_busy;

  op_t          w_op;
  logic         w_divZero;
  logic         w_start;
  logic [N:0]   w_sum;
  logic [N:0]   w_diff;
  logic [N-1:0] w_res;
  logic         w_carry;
  logic         w_neg;
  logic         w_des;
  logic         w_iterDone;
  logic [N-1:0] w_prodLo;
  logic [N-1:0] w_prodHi;
  logic [N-1:0] w_quot;
  logic [N-1:0] w_rem;
  logic [N-1:0] w_iterRes;
  logic         w_iterCarry;

  assign w_op      = op_t'(r_mode);
  assign w_divZero = ((w_op == OP_DIV) || (w_op == OP_MOD)) && (r_b == '0);
  assign w_start   = (r_state == CALC) && is_iter(w_op) && !w_divZero;
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};

  alu_iter_n #(.N(N)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .op      (w_op),
    .a       (r_a),
    .b       (r_b),
    .done    (w_iterDone),
    .prod_lo (w_prodLo),
    .prod_hi (w_prodHi),
    .quot    (w_quot),
    .rem     (w_rem)
  );

  // Single-cycle results; the DIV/MOD arm only matters for a zero divisor.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_neg   = 1'b0;
    w_des   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_neg   = w_sum[N-1];
        w_des   = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[N-1:0];
        w_carry = w_diff[N];
        w_neg   = w_diff[N-1];
        w_des   = (r_a[N-1] != r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);
      end
      OP_DIV, OP_MOD: begin
        w_res = '1;
        w_des = 1'b1;
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin
        w_res   = {r_a[N-2:0], 1'b0};
        w_carry = r_a[N-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, r_a[N-1:1]};
        w_carry = r_a[0];
      end
      OP_MUL: w_res = '0;
      default: w_des = (r_mode > OP_LAST);
    endcase
  end

  always_comb begin
    w_iterRes   = w_rem;
    w_iterCarry = 1'b0;
    if (w_op == OP_MUL) begin
      w_iterRes   = w_prodLo;
      w_iterCarry = |w_prodHi;
    end else if (w_op == OP_DIV) begin
      w_iterRes = w_quot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= '0;
      r_result   <= '0;
      r_neg      <= 1'b0;
      r_cero     <= 1'b0;
      r_carry    <= 1'b0;
      r_des      <= 1'b0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= in1;
            r_b       <= in2;
            r_mode    <= mode;
            r_state   <= CALC;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        CALC: begin
          if (w_start) begin
            r_state <= ITER;
          end else begin
            r_result   <= w_res;
            r_cero     <= (w_res == '0);
            r_carry    <= w_carry;
            r_neg      <= w_neg;
            r_des      <= w_des;
            r_state    <= HOLD;
            r_busy     <= 1'b0;
            r_outValid <= 1'b1;
          end
        end
        ITER: begin
          if (w_iterDone) begin
            r_result   <= w_iterRes;
            r_cero     <= (w_iterRes == '0);
            r_carry    <= w_iterCarry;
            r_neg      <= 1'b0;
            r_des      <= 1'b0;
            r_state    <= HOLD;
            r_busy     <= 1'b0;
            r_outValid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign out_neg   = r_neg;
  assign out_cero  = r_cero;
  assign out_carry = r_carry;
  assign out_des   = r_des;
  assign busy      = r_busy;

endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
Parametrised, handshaked successor to the registered ALU wrapper. It captures operands and opcode into input registers, then executes the operation. Single-cycle ops complete in one execute cycle. MUL, DIV and MOD run iteratively over N cycles. Result and flags are held in output registers until the consumer accepts them. It sits between the operand/switch front end and the display/BCD back end, and replaces free-running in/out flop stages with a valid/ready protocol.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  input  1  single clock, all state rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  operands/mode valid
in_ready  output  1  block can accept an operation
in1  input  N  operand A (unsigned; two's complement for ADD/SUB flags)
in2  input  N  operand B
mode  input  4  opcode
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  N  registered result
out_neg  output  1  negative flag
out_cero  output  1  zero flag
out_carry  output  1  carry/borrow/shift-out/high-product flag
out_des  output  1  overflow/error flag
busy  output  1  high in CALC or ITER

Behaviour:
- Reset (reset=0, async): state=IDLE, all operand/result/flag/counter registers=0, out_valid=0, busy=0, in_ready=1. Reset mid-ITER aborts the operation; no result is ever presented.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHL (by 1), 9 SHR (logical, by 1). Codes 10-15 are invalid.
- FSM states: IDLE, CALC, ITER, HOLD.
- IDLE: in_ready=1. On in_valid=1, capture in1/in2/mode into registers and go to CALC. Input changes after capture are ignored.
- CALC, single-cycle op or invalid code: register result and flags, go to HOLD.
- CALC, MUL: initialise product accumulator and counter=N-1, go to ITER.
- CALC, DIV/MOD with in2!=0: initialise remainder/quotient and counter=N-1, go to ITER.
- CALC, DIV/MOD with in2==0: result=all ones, des=1, carry=0, go to HOLD (no ITER).
- ITER: one shift-add (MUL, unsigned) or one restoring step (DIV/MOD, unsigned) per cycle. At counter==0, register result and flags and go to HOLD. Exactly N ITER cycles.
- Latency from the accept edge to out_valid=1: 2 cycles for single-cycle ops, invalid codes and divide-by-zero; N+2 cycles for MUL/DIV/MOD.
- HOLD: out_valid=1. result and flags stay stable while out_ready=0. On out_ready=1, go to IDLE with out_valid=0 next cycle. in_ready=0 in CALC/ITER/HOLD, so in_valid there is ignored.
- Width rules, result is always N bits:
  - ADD: sum[N-1:0], carry=sum[N].
  - SUB: in1-in2 mod 2^N, carry=borrow (in1<in2 unsigned).
  - MUL: low N bits of the 2N-bit product, carry=|product[2N-1:N].
  - DIV: quotient. MOD: remainder.
  - SHL: carry=in1[N-1]. SHR: carry=in1[0].
  - Logic ops: carry=0.
- Flags:
  - cero = (result==0) for all ops.
  - neg = result[N-1] for ADD/SUB, else 0.
  - des = signed overflow for ADD/SUB, 1 for divide-by-zero, 1 for an invalid code (result=0), else 0.
- Flags and result update only when entering HOLD.

Decomposition:
- Package alu_pkg:
  - op_t enum (4-bit opcodes above)
  - state_t enum (IDLE/CALC/ITER/HOLD)
  - function is_iter(op_t)
  - constant OP_LAST=9
- Sub-module alu_iter_n #(N): iterative MUL/DIV/MOD datapath with start, done, op, a, b, prod_lo, prod_hi, quot, rem. The top module keeps the FSM, handshake, single-cycle ops and flag logic.

Test Plan:
1. N=4, ADD 7+9 -> result=0, cero=1, carry=1, neg=0, des=0; out_valid 2 cycles after accept. ADD 7+1 -> result=8, neg=1, des=1.
2. SUB 3-5 -> result=4'hE, neg=1, carry=1, des=0. SUB 5-5 -> result=0, cero=1, carry=0.
3. MUL 6*5 -> result=4'hE, carry=1, out_valid 6 cycles after accept. MUL 3*4 -> result=4'hC, carry=0.
4. DIV 13/4 -> result=3 and MOD 13/4 -> result=1, each N+2=6 cycle latency. DIV 9/0 -> result=4'hF, des=1, latency 2. mode=12 -> result=0, des=1.
5. Backpressure: hold out_ready=0 for 5 cycles in HOLD -> result/flags unchanged, in_ready=0, a pulsed in_valid is ignored. Raise out_ready -> IDLE next cycle, then the next op is accepted normally.
6. Drive reset=0 asynchronously in the 2nd ITER cycle of MUL 15*15 -> out_valid/busy/result go to 0 immediately, in_ready=1. After release, AND 12&10 -> result=8, carry=0.
